serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller that computes a - b - borrow_in for WIDTH-bit operands using a single sub1 full-subtractor cell. The controller processes one bit per clock, LSB first. It is the area-minimal alternative to the ripple subtractor in the arithmetic unit and is used where one shared 1-bit subtractor cell is cheaper than WIDTH of them. It sequences operand shifting, carries the borrow between cycles in a flop, and presents a registered result with a start/done handshake.

---
 rtl/serial_sub_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_sub_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a - b - borrow_in controller built around one shared sub1 cell
// LSB first, one bit per clock; result registers update only on the last RUN cycle.

module sub1 (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic d,
    output logic borrow_out
);
    assign d          = a ^ b ^ borrow_in;
    assign borrow_out = (~a & (b | borrow_in)) | (b & borrow_in);
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             borrow_q;
    logic [CW-1:0]    count;
    logic             bit_d;
    logic             bit_borrow;
    logic             last_bit;
    logic [WIDTH-1:0] res_next;

    sub1 u_sub1 (
        .a          (a_sr[0]),
        .b          (b_sr[0]),
        .borrow_in  (borrow_q),
        .d          (bit_d),
        .borrow_out (bit_borrow)
    );

    assign last_bit = (count == CW'(WIDTH - 1));
    assign res_next = {bit_d, res_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture, per-bit shifting and the held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            borrow_q   <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_q <= borrow_in;
                        count    <= '0;
                    end
                end
                RUN: begin
                    res_sr   <= res_next;
                    a_sr     <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr     <= {1'b0, b_sr[WIDTH-1:1]};
                    borrow_q <= bit_borrow;
                    count    <= count + 1'b1;
                    if (last_bit) begin
                        diff       <= res_next;
                        borrow_out <= bit_borrow;
                        zero       <= (res_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - self-checking bench for serial_sub_ctrl at WIDTH=4 and WIDTH=8

module tb_serial_sub_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start4, start8;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;
    logic       bin4, bin8;
    logic       busy4, done4, bout4, zero4;
    logic       busy8, done8, bout8, zero8;
    logic [3:0] diff4;
    logic [7:0] diff8;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] prev4 = 4'd0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
        logic       zero;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .borrow_in(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bout4), .zero(zero4)
    );

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .borrow_in(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8), .zero(zero8)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tbin,
                       input logic [3:0] ed, input logic eb, input logic ez);
        int n;
        @(negedge clk);
        a4 = ta; b4 = tb_; bin4 = tbin; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; a4 = ~ta; b4 = ~tb_; bin4 = ~tbin;
        n = 1;
        chk("busy_run4", busy4, 1);
        chk("hold_diff4", diff4, prev4);
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency4", n, 5);
        chk("diff4", diff4, ed);
        chk("bout4", bout4, eb);
        chk("zero4", zero4, ez);
        prev4 = ed;
        @(negedge clk);
        chk("done_drop4", done4, 0);
        chk("busy_drop4", busy4, 0);
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                       input bit check_lat);
        int n;
        logic [8:0] model;
        model = {1'b0, ta} - {1'b0, tb_} - {8'd0, tbin};
        @(negedge clk);
        a8 = ta; b8 = tb_; bin8 = tbin; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0; a8 = ~ta; b8 = ~tb_;
        n = 1;
        while (!done8 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (check_lat) chk("latency8", n, 9);
        else if (n >= 30) chk("timeout8", n, 9);
        chk("diff8", diff8, model[7:0]);
        chk("bout8", bout8, model[8]);
        chk("zero8", zero8, (model[7:0] == 8'd0));
    endtask

    initial begin
        int n;
        int ndone;
        int done_at [3];
        logic [3:0] exp_d [3];
        logic       exp_b [3];
        logic       exp_z [3];

        vecs[0] = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b0};
        vecs[1] = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1, 1'b0};
        vecs[2] = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0};
        vecs[3] = '{4'd5,  4'd5,  1'b0, 4'd0,  1'b0, 1'b1};
        vecs[4] = '{4'd15, 4'd0,  1'b1, 4'd14, 1'b0, 1'b0};
        vecs[5] = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1, 1'b0};

        rst = 1'b1; start4 = 1'b0; start8 = 1'b0;
        a4 = '0; b4 = '0; bin4 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy4", busy4, 0);
        chk("rst_done4", done4, 0);
        chk("rst_diff4", diff4, 0);
        chk("rst_bout4", bout4, 0);
        chk("rst_zero4", zero4, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_diff8", diff8, 0);

        for (int i = 0; i < 6; i++)
            op4(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout, vecs[i].zero);

        // start pulses during RUN and DONE must be ignored
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0; n = 1;
        @(negedge clk);
        n = 2; a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
        chk("ign_hold_diff", diff4, prev4);
        @(negedge clk);
        n = 3; start4 = 1'b0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ign_latency", n, 5);
        chk("ign_diff", diff4, 6);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("ign_done_drop", done4, 0);
        chk("ign_busy_drop", busy4, 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4 || busy4) ndone++;
        end
        chk("ign_no_extra", ndone, 0);
        chk("ign_diff_held", diff4, 6);
        prev4 = 4'd6;

        // reset in the second RUN cycle discards the operation
        @(negedge clk);
        a4 = 4'd9; b4 = 4'd3; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", busy4, 0);
        chk("mrst_done", done4, 0);
        chk("mrst_diff", diff4, 0);
        chk("mrst_bout", bout4, 0);
        chk("mrst_zero", zero4, 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) ndone++;
        end
        chk("mrst_no_done", ndone, 0);
        prev4 = 4'd0;
        op4(4'd7, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0);

        // start held high: back-to-back operations every 6 cycles
        exp_d[0] = 4'd8; exp_b[0] = 1'b0; exp_z[0] = 1'b0;
        exp_d[1] = 4'd8; exp_b[1] = 1'b1; exp_z[1] = 1'b0;
        exp_d[2] = 4'd0; exp_b[2] = 1'b0; exp_z[2] = 1'b1;
        @(negedge clk);
        a4 = 4'd12; b4 = 4'd4; bin4 = 1'b0; start4 = 1'b1;
        @(posedge clk);
        ndone = 0; n = 0;
        while (ndone < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin a4 = 4'd4; b4 = 4'd12; end
            if (done4) begin
                done_at[ndone] = n;
                chk("b2b_diff", diff4, exp_d[ndone]);
                chk("b2b_bout", bout4, exp_b[ndone]);
                chk("b2b_zero", zero4, exp_z[ndone]);
                if (ndone == 1) begin a4 = 4'd15; b4 = 4'd15; end
                if (ndone == 2) start4 = 1'b0;
                ndone++;
            end
        end
        start4 = 1'b0;
        chk("b2b_count", ndone, 3);
        if (ndone == 3) begin
            chk("b2b_first", done_at[0], 5);
            chk("b2b_gap1", done_at[1] - done_at[0], 6);
            chk("b2b_gap2", done_at[2] - done_at[1], 6);
        end
        repeat (10) @(negedge clk);
        chk("b2b_idle", busy4, 0);

        // WIDTH=8 directed and random sweep
        op8(8'd200, 8'd1, 1'b1, 1'b1);
        chk("w8_diff198", diff8, 198);
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), (i < 4));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
